// File: rtl/srff_bank_driver.sv
// srff_bank_driver
// Write-side controller for a bank of WIDTH SR flip-flops.
// A valid/ready request carries a target value and an update mask. The
// controller drives one cycle of S/R pulses derived from the SR excitation
// table, waits SETTLE_CYC cycles, and then returns to IDLE with a done pulse.
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE, including the done
// cycle. in_valid is ignored while in_ready is low and is never queued.
// Optional feature macro SRDRV_READBACK_EN: adds a CHECK state that compares
// q_in against the tracked shadow and raises a sticky err/err_bits. When the
// macro is undefined, q_in and err_clr are unused and err/err_bits read 0.
module srff_bank_driver #(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] shadow,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits,
    input  logic             err_clr
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

`ifdef SRDRV_READBACK_EN
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] chg;

    // Bits that must move: selected by the mask and different from the bank.
    always_comb begin
        chg = in_mask & (in_data ^ shadow);
    end

    // Main FSM. S/R are registered at accept, so they are visible exactly
    // during DRIVE; a set bit and a reset bit can never coincide because each
    // is qualified by opposite polarities of the same data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            s_out    <= '0;
            r_out    <= '0;
            shadow   <= '0;
            done     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            done  <= 1'b0;
            s_out <= '0;
            r_out <= '0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        mask_q   <= in_mask;
                        s_out    <= chg & in_data;
                        r_out    <= chg & ~in_data;
                        in_ready <= 1'b0;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    shadow <= (shadow & ~mask_q) | (data_q & mask_q);
                    cnt    <= CW'(SETTLE_CYC - 1);
                    state  <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) begin
`ifdef SRDRV_READBACK_EN
                        state <= CHECK;
`else
                        state    <= IDLE;
                        done     <= 1'b1;
                        in_ready <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef SRDRV_READBACK_EN
                CHECK: begin
                    state    <= IDLE;
                    done     <= 1'b1;
                    in_ready <= 1'b1;
                end
`endif
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef SRDRV_READBACK_EN
    logic [WIDTH-1:0] mm;

    // Readback difference against the tracked bank state.
    always_comb begin
        mm = q_in ^ shadow;
    end

    // Sticky mismatch flag; a mismatch detected in CHECK wins over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= 1'b0;
            err_bits <= '0;
        end else if (state == CHECK && mm != '0) begin
            err      <= 1'b1;
            err_bits <= mm;
        end else if (err_clr) begin
            err      <= 1'b0;
            err_bits <= '0;
        end
    end
`else
    logic unused_readback;

    assign unused_readback = ^{q_in, err_clr};
    assign err      = 1'b0;
    assign err_bits = '0;
`endif

endmodule

// File: tb/tb_srff_bank_driver.sv
// tb_srff_bank_driver
// Directed bench for srff_bank_driver (WIDTH=8, SETTLE_CYC=2). A timeline
// model (age of the current request in cycles) predicts every output each
// cycle; literal expectations pin the model at the interesting points.
// A behavioural SR flop bank feeds q_in; 'inject' flips readback bits.
module tb_srff_bank_driver;

    localparam int WIDTH = 8;
    localparam int S     = 2;
`ifdef SRDRV_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int LAT = RB ? 2 + S : 1 + S;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_mask;
    logic [WIDTH-1:0] s_out;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] shadow;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] err_bits;
    logic             err_clr;

    logic [WIDTH-1:0] bank;
    logic [WIDTH-1:0] inject;

    int n_checks;
    int n_fail;

    srff_bank_driver #(.WIDTH(WIDTH), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask),
        .s_out(s_out), .r_out(r_out), .q_in(q_in),
        .shadow(shadow), .done(done),
        .err(err), .err_bits(err_bits), .err_clr(err_clr)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- behavioural SR flop bank (reset to 0) ----
    always @(posedge clk or posedge rst) begin
        if (rst) bank <= '0;
        else     bank <= (bank & ~r_out) | s_out;
    end
    assign q_in = bank ^ inject;

    // ---- comparison helper ----
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- timeline model ----
    // age 0: idle; age 1: drive cycle; age LAT+1: done cycle (idle again).
    int               age;
    logic [WIDTH-1:0] m_sh, m_s, m_r, m_data, m_mask, m_eb, mmv;
    logic             m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age = 0; m_sh = '0; m_s = '0; m_r = '0;
            m_data = '0; m_mask = '0; m_err = 1'b0; m_eb = '0;
        end else begin
            if (RB && age == LAT) begin
                mmv = q_in ^ m_sh;
                if (mmv != '0) begin m_err = 1'b1; m_eb = mmv; end
                else if (err_clr) begin m_err = 1'b0; m_eb = '0; end
            end else if (RB && err_clr) begin
                m_err = 1'b0; m_eb = '0;
            end
            if (age == LAT + 1) age = 0;
            if (age == 0) begin
                if (in_valid) begin
                    m_data = in_data;
                    m_mask = in_mask;
                    for (int i = 0; i < WIDTH; i++) begin
                        m_s[i] = m_mask[i] && (m_data[i] != m_sh[i]) && m_data[i];
                        m_r[i] = m_mask[i] && (m_data[i] != m_sh[i]) && !m_data[i];
                    end
                    age = 1;
                end
            end else begin
                if (age == 1)
                    for (int i = 0; i < WIDTH; i++)
                        if (m_mask[i]) m_sh[i] = m_data[i];
                age++;
            end
        end
    end

    // ---- per-cycle compare against the model ----
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_s_out", s_out, (age == 1) ? m_s : '0);
            chk("model_r_out", r_out, (age == 1) ? m_r : '0);
            chk("s_and_r_zero", s_out & r_out, '0);
            chk("model_shadow", shadow, m_sh);
            chk("model_done", done, age == LAT + 1);
            chk("model_in_ready", in_ready, (age == 0) || (age == LAT + 1));
            chk("model_err", err, m_err);
            chk("model_err_bits", err_bits, m_eb);
        end
    end

    // ---- driver tasks ----
    // Present a request for one edge; returns on the drive-cycle negedge.
    task automatic write_req(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called on the drive-cycle negedge; returns on the done negedge with
    // the number of edges from accept to done.
    task automatic wait_done(output int lat);
        int cnt;
        cnt = 1;
        while (done !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", cnt);
        end
        lat = cnt - 1;
    endtask

    // ---- directed sequence ----
    initial begin
        int lat;
        n_checks = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0;
        err_clr = 1'b0; inject = '0;
        repeat (3) @(negedge clk);

        // 1: reset state
        chk("rst_s_out", s_out, 8'h00);
        chk("rst_r_out", r_out, 8'h00);
        chk("rst_shadow", shadow, 8'h00);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 2: full write 0xA5 over 0x00
        write_req(8'hA5, 8'hFF);
        chk("t2_s_out", s_out, 8'hA5);
        chk("t2_r_out", r_out, 8'h00);
        wait_done(lat);
        chk("t2_latency", lat, RB ? 4 : 3);
        chk("t2_shadow", shadow, 8'hA5);

        // 3: masked write, low nibble held
        write_req(8'h0F, 8'hF0);
        chk("t3_s_out", s_out, 8'h00);
        chk("t3_r_out", r_out, 8'hA0);
        wait_done(lat);
        chk("t3_shadow", shadow, 8'h05);

        // 5: readback mismatch, clear, clean check, set-wins-over-clear
        inject = 8'h01;
        write_req(8'h05, 8'h00);
        chk("t5_nochange_s", s_out, 8'h00);
        chk("t5_nochange_r", r_out, 8'h00);
        wait_done(lat);
        chk("t5_err", err, RB);
        chk("t5_err_bits", err_bits, RB ? 8'h01 : 8'h00);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t5_clr_err", err, 1'b0);
        chk("t5_clr_bits", err_bits, 8'h00);
        inject = 8'h00;
        write_req(8'h05, 8'h00);
        wait_done(lat);
        chk("t5_clean_err", err, 1'b0);
        inject = 8'h10;
        err_clr = 1'b1;
        write_req(8'h05, 8'h00);
        wait_done(lat);
        chk("t5_setwins_err", err, RB);
        chk("t5_setwins_bits", err_bits, RB ? 8'h10 : 8'h00);
        @(negedge clk);
        err_clr = 1'b0;
        inject = 8'h00;
        chk("t5_clr2_err", err, 1'b0);

        // 4: busy, in_valid held high, back-to-back on the done cycle
        in_valid = 1'b1; in_data = 8'h3C; in_mask = 8'hFF;
        @(negedge clk);
        chk("t4_first_s", s_out, 8'h38);
        chk("t4_first_r", r_out, 8'h01);
        in_data = 8'hC3; in_mask = 8'h0F;
        wait_done(lat);
        chk("t4_first_latency", lat, RB ? 4 : 3);
        chk("t4_shadow_mid", shadow, 8'h3C);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t4_second_s", s_out, 8'h03);
        chk("t4_second_r", r_out, 8'h0C);
        wait_done(lat);
        chk("t4_shadow", shadow, 8'h33);

        // 6: reset in the middle of a drive cycle
        write_req(8'h00, 8'hFF);
        wait_done(lat);
        write_req(8'hA5, 8'hFF);
        chk("t6_drive_s", s_out, 8'hA5);
        rst = 1'b1;
        #1;
        chk("t6_rst_s_out", s_out, 8'h00);
        chk("t6_rst_shadow", shadow, 8'h00);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t6_no_done", done, 1'b0);
        end
        chk("t6_in_ready", in_ready, 1'b1);
        write_req(8'h81, 8'h81);
        chk("t6_after_s", s_out, 8'h81);
        wait_done(lat);
        chk("t6_after_shadow", shadow, 8'h81);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
